// File: rtl/uart_bus_link_pkg.sv
// uart_bus_link_pkg: shared constants for the UART-to-bus bridge.
//   Command opcodes, response bytes and the bridge FSM state type.
package uart_bus_link_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_AW,
    S_WDATA,
    S_WBEAT,
    S_AR,
    S_RBEAT,
    S_TXW,
    S_ACK
  } state_t;

endpackage

// File: rtl/uart_bus_link_phy.sv
// uart_bus_link_phy: bit-level UART receiver/transmitter with CLK_DIV divider.
//   clk, rst            : clock, synchronous active-high reset
//   rxd / txd           : serial lines, idle high
//   rx_valid/data/err   : one-cycle pulse per received byte (err = parity error)
//   tx_valid/data/ready : byte handshake, accepted when tx_valid && tx_ready
// Build option: define UART_PARITY_EN for 8E1 frames (default 8N1).
module uart_bus_link_phy #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned STOP_IDX = FRAME_BITS - 1;
  localparam int unsigned CW       = $clog2(CLK_DIV);

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_sr;
  logic          rx_valid_r;
  logic [7:0]    rx_data_r;
`ifdef UART_PARITY_EN
  logic          rx_pbit;
  logic          rx_err_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // prev resets low so a line already low after reset is not a start edge
      rx_s1      <= 1'b0;
      rx_s2      <= 1'b0;
      rx_prev    <= 1'b0;
      rx_act     <= 1'b0;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sr      <= '0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
`ifdef UART_PARITY_EN
      rx_pbit    <= 1'b0;
      rx_err_r   <= 1'b0;
`endif
    end else begin
      rx_s1      <= rxd;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_valid_r <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= CW'(CLK_DIV / 2 - 1);
          rx_idx <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= CW'(CLK_DIV - 1);
        rx_idx <= rx_idx + 1'b1;
        if (rx_idx == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;  // start bit gone high: glitch
        end else if (rx_idx <= 4'd8) begin
          rx_sr <= {rx_s2, rx_sr[7:1]};
        end else if (rx_idx == 4'(STOP_IDX)) begin
          rx_act <= 1'b0;
          if (rx_s2) begin
            rx_valid_r <= 1'b1;
            rx_data_r  <= rx_sr;
`ifdef UART_PARITY_EN
            rx_err_r   <= (^rx_sr) ^ rx_pbit;
`endif
          end
        end
`ifdef UART_PARITY_EN
        else begin
          rx_pbit <= rx_s2;
        end
`endif
      end
    end
  end

  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
`ifdef UART_PARITY_EN
  assign rx_err   = rx_err_r;
`else
  assign rx_err   = 1'b0;
`endif

  // ---------------- transmitter ----------------
  logic                  tx_act;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_act <= 1'b0;
      tx_sr  <= '1;
      tx_cnt <= '0;
      tx_idx <= '0;
    end else if (!tx_act) begin
      if (tx_valid) begin
`ifdef UART_PARITY_EN
        tx_sr <= {1'b1, ^tx_data, tx_data, 1'b0};
`else
        tx_sr <= {1'b1, tx_data, 1'b0};
`endif
        tx_act <= 1'b1;
        tx_cnt <= CW'(CLK_DIV - 1);
        tx_idx <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else begin
      tx_cnt <= CW'(CLK_DIV - 1);
      tx_sr  <= {1'b1, tx_sr[FRAME_BITS-1:1]};
      if (tx_idx == 4'(FRAME_BITS - 1)) tx_act <= 1'b0;
      else                              tx_idx <= tx_idx + 1'b1;
    end
  end

  assign txd      = tx_act ? tx_sr[0] : 1'b1;
  assign tx_ready = !tx_act;

endmodule

// File: rtl/uart_bus_link.sv
// uart_bus_link: UART command interface bridging to a burst read/write bus.
//   Command: opcode (0x57 write / 0x52 read), NA address bytes MSB first,
//   length byte (beats-1). Write data follows as NB bytes per beat, MSB first.
//   Read data is returned on txd MSB first; ACK 0x06 ends a command,
//   NAK 0x15 reports bad opcode, inter-byte timeout or parity error.
//   Ports: clk, rst (sync, active high), en, rxd, txd, busy,
//          aw*/w* write channels, ar*/r* read channels.
// Build option: define UART_PARITY_EN for 8E1 framing.
module uart_bus_link
  import uart_bus_link_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned LEN_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rxd,
  output logic              txd,
  output logic              busy,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned NA  = (ADDR_W + 7) / 8;
  localparam int unsigned TMO = 16 * 10 * CLK_DIV;

  logic       rx_valid, rx_err, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;

  uart_bus_link_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .txd      (txd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  state_t            state, state_n;
  logic              wr_r, wr_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [LEN_W-1:0]  len_r, len_n, beat_r, beat_n;
  logic [DATA_W-1:0] wdata_r, wdata_n, rbuf_r, rbuf_n;
  logic [7:0]        cnt_r, cnt_n, resp_r, resp_n;
  logic [31:0]       tmo_r, tmo_n;
  logic              take, timeout;

  assign take    = en && rx_valid;
  assign timeout = (tmo_r == 32'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      len_r   <= '0;
      beat_r  <= '0;
      wdata_r <= '0;
      rbuf_r  <= '0;
      cnt_r   <= '0;
      resp_r  <= '0;
      tmo_r   <= '0;
    end else begin
      state   <= state_n;
      wr_r    <= wr_n;
      addr_r  <= addr_n;
      len_r   <= len_n;
      beat_r  <= beat_n;
      wdata_r <= wdata_n;
      rbuf_r  <= rbuf_n;
      cnt_r   <= cnt_n;
      resp_r  <= resp_n;
      tmo_r   <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_n     = wr_r;
    addr_n   = addr_r;
    len_n    = len_r;
    beat_n   = beat_r;
    wdata_n  = wdata_r;
    rbuf_n   = rbuf_r;
    cnt_n    = cnt_r;
    resp_n   = resp_r;
    tmo_n    = '0;
    tx_valid = 1'b0;
    tx_data  = resp_r;

    // Idle-line timer only runs while waiting for command/data bytes.
    if ((state == S_HDR || state == S_WDATA) && !take) tmo_n = tmo_r + 32'd1;

    case (state)
      S_IDLE: begin
        if (take) begin
          cnt_n  = '0;
          beat_n = '0;
          if (!rx_err && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
            wr_n    = (rx_data == OP_WRITE);
            state_n = S_HDR;
          end else begin
            resp_n  = RESP_NAK;
            state_n = S_ACK;
          end
        end
      end
      S_HDR: begin
        if (take) begin
          if (rx_err) begin
            resp_n  = RESP_NAK;
            state_n = S_ACK;
          end else if (cnt_r < 8'(NA)) begin
            addr_n = ADDR_W'({addr_r, rx_data});  // excess high bits fall off
            cnt_n  = cnt_r + 8'd1;
          end else begin
            len_n   = rx_data[LEN_W-1:0];
            cnt_n   = '0;
            state_n = wr_r ? S_AW : S_AR;
          end
        end else if (timeout) begin
          resp_n  = RESP_NAK;
          state_n = S_ACK;
        end
      end
      S_AW: begin
        // Data bytes are still collected while the address handshake stalls;
        // a corrupted byte here is dropped and the idle timer catches it later.
        if (take && !rx_err && cnt_r < 8'(NB)) begin
          wdata_n = DATA_W'({wdata_r, rx_data});
          cnt_n   = cnt_r + 8'd1;
        end
        if (awready) begin
          if (cnt_n == 8'(NB)) begin
            cnt_n   = '0;
            state_n = S_WBEAT;
          end else begin
            state_n = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (take) begin
          if (rx_err) begin
            resp_n  = RESP_NAK;
            state_n = S_ACK;
          end else begin
            wdata_n = DATA_W'({wdata_r, rx_data});
            cnt_n   = cnt_r + 8'd1;
            if (cnt_n == 8'(NB)) begin
              cnt_n   = '0;
              state_n = S_WBEAT;
            end
          end
        end else if (timeout) begin
          resp_n  = RESP_NAK;
          state_n = S_ACK;
        end
      end
      S_WBEAT: begin
        if (wready) begin
          if (beat_r == len_r) begin
            resp_n  = RESP_ACK;
            state_n = S_ACK;
          end else begin
            beat_n  = beat_r + 1'b1;
            state_n = S_WDATA;
          end
        end
      end
      S_AR: begin
        if (arready) begin
          beat_n  = '0;
          state_n = S_RBEAT;
        end
      end
      S_RBEAT: begin
        if (rvalid) begin
          rbuf_n  = rdata;
          cnt_n   = '0;
          state_n = S_TXW;
        end
      end
      S_TXW: begin
        tx_valid = 1'b1;
        tx_data  = rbuf_r[DATA_W-1 -: 8];
        if (tx_ready) begin
          rbuf_n = rbuf_r << 8;
          cnt_n  = cnt_r + 8'd1;
          if (cnt_r == 8'(NB - 1)) begin
            cnt_n = '0;
            if (beat_r == len_r) begin
              resp_n  = RESP_ACK;
              state_n = S_ACK;
            end else begin
              beat_n  = beat_r + 1'b1;
              state_n = S_RBEAT;
            end
          end
        end
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = resp_r;
        if (tx_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign awaddr  = addr_r;
  assign awlen   = len_r;
  assign awvalid = (state == S_AW);
  assign wdata   = wdata_r;
  assign wvalid  = (state == S_WBEAT);
  assign wlast   = wvalid && (beat_r == len_r);
  assign araddr  = addr_r;
  assign arlen   = len_r;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_RBEAT);

endmodule
